mem_access_unit: RTL and testbench

- Requester-side initiator for the data cache word interface: address, i_val, op_type (0 read / 1 write), combinational o_val.
- Takes one load/store at a time from the execute stage using RISC-V funct3 encoding.
- Converts byte addresses to word indices and handles byte, halfword and word sizes.
- Sub-word stores use read-modify-write. Load data is sign- or zero-extended.
- Returns one response per request over a valid/ready handshake.

---
 rtl/mem_access_unit_pkg.sv | 35 +++
 rtl/mau_lane_align.sv | 46 ++++
 rtl/mem_access_unit.sv | 140 ++++++++++++++
 tb/tb_mem_access_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared state encodings, funct3 codes and cache op encoding for the memory access unit.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRd   = 2'd1,
    StWr   = 2'd2,
    StResp = 2'd3
  } mau_state_e;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // Illegal funct3 for the direction, or an address not aligned to the access size.
  function automatic logic access_fault(input logic we, input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
    logic fault;
    case (funct3)
      F3_B:    fault = 1'b0;
      F3_H:    fault = addr_lo[0];
      F3_W:    fault = |addr_lo;
      F3_BU:   fault = we;
      F3_HU:   fault = we | addr_lo[0];
      default: fault = 1'b1;
    endcase
    return fault;
  endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Byte/halfword lane handling: load extract with sign/zero extension and store merge.
module mau_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [4:0]  bit_ofs;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    bit_ofs  = {addr_lo, 3'b000};
    byte_sel = word[bit_ofs +: 8];
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];

    load_data = word;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_data = {24'd0, byte_sel};
      F3_HU:   load_data = {16'd0, half_sel};
      default: load_data = word;
    endcase

    store_word = wdata;
    case (funct3)
      F3_B: begin
        store_word = word;
        store_word[bit_ofs +: 8] = wdata[7:0];
      end
      F3_H: begin
        store_word = word;
        if (addr_lo[1]) store_word[31:16] = wdata[15:0];
        else            store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for the word-indexed data cache; sub-word stores use read-modify-write.
// Optional load/store completion counters are built when MAU_PERF_CNT_EN is defined.
`ifndef _CACHE_SIZE
`define _CACHE_SIZE 63
`endif

module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned CACHE_SIZE = `_CACHE_SIZE,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [31:0]       c_address,
  output logic [31:0]       c_i_val,
  output logic              c_op_type,
  input  logic [31:0]       c_o_val,
  output logic [31:0]       cnt_loads,
  output logic [31:0]       cnt_stores
);

  mau_state_e  state_q, state_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] c_addr_q;
  logic [31:0] c_wdata_q;

  logic        accept;
  logic        req_fault;
  logic [31:0] req_idx;
  logic [31:0] load_data;
  logic [31:0] store_word;

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid && req_ready;
  assign req_idx   = 32'(req_addr[ADDR_W-1:2]);
  assign req_fault = access_fault(req_we, req_funct3, req_addr[1:0]) || (req_idx > CACHE_SIZE);

  mau_lane_align u_lane_align (
    .funct3     (funct3_q),
    .addr_lo    (addr_lo_q),
    .word       (c_o_val),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_fault)                           state_d = StResp;
          else if (req_we && req_funct3 == F3_W)   state_d = StWr;
          else                                     state_d = StRd;
        end
      end
      StRd:    state_d = we_q ? StWr : StResp;
      StWr:    state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      we_q      <= 1'b0;
      funct3_q  <= 3'd0;
      addr_lo_q <= 2'd0;
      wdata_q   <= 32'd0;
      err_q     <= 1'b0;
      rdata_q   <= 32'd0;
      c_addr_q  <= 32'd0;
      c_wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q      <= req_we;
        funct3_q  <= req_funct3;
        addr_lo_q <= req_addr[1:0];
        wdata_q   <= req_wdata;
        err_q     <= req_fault;
        rdata_q   <= 32'd0;
        // Faulting requests leave the cache-facing address and data untouched.
        if (!req_fault) begin
          c_addr_q <= req_idx;
          if (req_we && req_funct3 == F3_W) c_wdata_q <= req_wdata;
        end
      end
      if (state_q == StRd) begin
        if (we_q) c_wdata_q <= store_word;
        else      rdata_q   <= load_data;
      end
    end
  end

  assign c_address  = c_addr_q;
  assign c_i_val    = c_wdata_q;
  // Gated by rst so a write in flight when reset arrives never reaches the cache.
  assign c_op_type  = (state_q == StWr) && !rst ? OP_WRITE : OP_READ;
  assign resp_valid = (state_q == StResp);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = resp_valid ? rdata_q : 32'd0;

`ifdef MAU_PERF_CNT_EN
  logic [31:0] cnt_loads_q, cnt_stores_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_loads_q  <= 32'd0;
      cnt_stores_q <= 32'd0;
    end else if (state_q == StResp && !err_q) begin
      if (we_q) cnt_stores_q <= cnt_stores_q + 32'd1;
      else      cnt_loads_q  <= cnt_loads_q + 32'd1;
    end
  end

  assign cnt_loads  = cnt_loads_q;
  assign cnt_stores = cnt_stores_q;
`else
  assign cnt_loads  = 32'd0;
  assign cnt_stores = 32'd0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small behavioural word cache.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] c_address;
  logic [31:0] c_i_val;
  logic        c_op_type;
  logic [31:0] c_o_val;
  logic [31:0] cnt_loads;
  logic [31:0] cnt_stores;

  logic        mem_clr = 1'b1;
  logic [31:0] mem [0:63];

  int total = 0;
  int bad   = 0;

  int          r_lat, r_wr_cnt, r_wr_cyc, n_resp, n_ready;
  logic [31:0] r_rdata, r_wr_addr, r_wr_data;
  logic        r_err, r_op_seen;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .c_address  (c_address),
    .c_i_val    (c_i_val),
    .c_op_type  (c_op_type),
    .c_o_val    (c_o_val),
    .cnt_loads  (cnt_loads),
    .cnt_stores (cnt_stores)
  );

  assign c_o_val = mem[c_address[5:0]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
    end else if (c_op_type) begin
      mem[c_address[5:0]] <= c_i_val;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request and follow it until its response (bounded to 8 cycles).
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata);
    bit done;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    r_lat = 0; r_wr_cnt = 0; r_wr_cyc = 0; r_rdata = 32'hx; r_err = 1'bx;
    r_wr_addr = 32'hx; r_wr_data = 32'hx; r_op_seen = 1'b0; done = 1'b0;
    for (int i = 1; i <= 8 && !done; i++) begin
      @(negedge clk);
      if (c_op_type) begin
        r_wr_cnt++; r_wr_cyc = i; r_wr_addr = c_address; r_wr_data = c_i_val; r_op_seen = 1'b1;
      end
      if (resp_valid) begin
        r_lat = i; r_rdata = resp_rdata; r_err = resp_err; done = 1'b1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst_c_address", c_address, 32'd0);
    check("rst_c_i_val", c_i_val, 32'd0);
    check("rst_c_op_type", 32'(c_op_type), 32'd0);
    check("rst_cnt_loads", cnt_loads, 32'd0);
    check("rst_cnt_stores", cnt_stores, 32'd0);
    rst = 1'b0; mem_clr = 1'b0;

    // Preload words 5 and 3 with SW
    do_req(1'b1, 3'd2, 32'h14, 32'h80F1_7F22);
    check("sw5_lat", 32'(r_lat), 32'd2);
    check("sw5_wr_cyc", 32'(r_wr_cyc), 32'd1);
    check("sw5_addr", r_wr_addr, 32'd5);
    check("sw5_data", r_wr_data, 32'h80F1_7F22);
    check("sw5_rdata", r_rdata, 32'd0);
    do_req(1'b1, 3'd2, 32'h0C, 32'h1122_3344);
    check("sw3_err", 32'(r_err), 32'd0);

    // Byte/halfword loads with sign and zero extension
    do_req(1'b0, 3'd0, 32'h15, 32'd0);
    check("lb15_data", r_rdata, 32'h0000_007F);
    check("lb15_lat", 32'(r_lat), 32'd2);
    check("lb15_nowr", 32'(r_wr_cnt), 32'd0);
    do_req(1'b0, 3'd0, 32'h17, 32'd0);
    check("lb17_data", r_rdata, 32'hFFFF_FF80);
    check("lb17_lat", 32'(r_lat), 32'd2);
    do_req(1'b0, 3'd4, 32'h17, 32'd0);
    check("lbu17_data", r_rdata, 32'h0000_0080);
    check("lbu17_lat", 32'(r_lat), 32'd2);
    do_req(1'b0, 3'd1, 32'h16, 32'd0);
    check("lh16_data", r_rdata, 32'hFFFF_80F1);
    do_req(1'b0, 3'd5, 32'h14, 32'd0);
    check("lhu14_data", r_rdata, 32'h0000_7F22);

    // Sub-word stores: read-modify-write
    do_req(1'b1, 3'd1, 32'h0E, 32'hAAAA_BEEF);
    check("sh_lat", 32'(r_lat), 32'd3);
    check("sh_wr_cnt", 32'(r_wr_cnt), 32'd1);
    check("sh_wr_cyc", 32'(r_wr_cyc), 32'd2);
    check("sh_addr", r_wr_addr, 32'd3);
    check("sh_data", r_wr_data, 32'hBEEF_3344);
    check("sh_err", 32'(r_err), 32'd0);
    do_req(1'b1, 3'd0, 32'h0D, 32'h0000_005A);
    check("sb_data", r_wr_data, 32'hBEEF_5A44);
    check("sb_lat", 32'(r_lat), 32'd3);

    // SW then LW round trip
    do_req(1'b1, 3'd2, 32'h08, 32'hDEAD_BEEF);
    check("sw2_wr_cyc", 32'(r_wr_cyc), 32'd1);
    check("sw2_addr", r_wr_addr, 32'd2);
    do_req(1'b0, 3'd2, 32'h08, 32'd0);
    check("lw2_data", r_rdata, 32'hDEAD_BEEF);
    check("lw2_lat", 32'(r_lat), 32'd2);

    // Errors: misaligned, illegal funct3, out of range; word 63 is the last legal index
    do_req(1'b0, 3'd2, 32'h06, 32'd0);
    check("lw06_err", 32'(r_err), 32'd1);
    check("lw06_lat", 32'(r_lat), 32'd1);
    check("lw06_rdata", r_rdata, 32'd0);
    do_req(1'b0, 3'd1, 32'h01, 32'd0);
    check("lh01_err", 32'(r_err), 32'd1);
    check("lh01_lat", 32'(r_lat), 32'd1);
    do_req(1'b0, 3'd3, 32'h10, 32'd0);
    check("f3_3_err", 32'(r_err), 32'd1);
    check("f3_3_noop", 32'(r_op_seen), 32'd0);
    do_req(1'b1, 3'd4, 32'h10, 32'h1234_5678);
    check("sbu_err", 32'(r_err), 32'd1);
    check("sbu_nowr", 32'(r_wr_cnt), 32'd0);
    do_req(1'b0, 3'd2, 32'h100, 32'd0);
    check("oor_err", 32'(r_err), 32'd1);
    do_req(1'b0, 3'd2, 32'hFC, 32'd0);
    check("top_err", 32'(r_err), 32'd0);
    check("top_lat", 32'(r_lat), 32'd2);

    // Reset during the WR cycle of an SB: write dropped, no response
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h14;
    req_wdata = 32'h0000_0011;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rmw_rd_op", 32'(c_op_type), 32'd0);
    @(negedge clk);
    check("rmw_wr_op", 32'(c_op_type), 32'd1);
    rst = 1'b1;
    #1 check("rmw_rst_op", 32'(c_op_type), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("rmw_no_resp", 32'(resp_valid), 32'd0);
    check("rmw_ready", 32'(req_ready), 32'd1);
    do_req(1'b0, 3'd2, 32'h14, 32'd0);
    check("rmw_unchanged", r_rdata, 32'h80F1_7F22);

    // Counters start from a clean reset
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;

    // req_valid held high: one acceptance per IDLE visit (3 loads in 9 cycles)
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h08;
    n_resp = 0; n_ready = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (resp_valid) n_resp++;
      if (req_ready) n_ready++;
    end
    req_valid = 1'b0;
    check("hold_resp_cnt", 32'(n_resp), 32'd3);
    check("hold_ready_cnt", 32'(n_ready), 32'd3);

    do_req(1'b1, 3'd2, 32'h28, 32'h0BAD_F00D);
    do_req(1'b1, 3'd0, 32'h29, 32'h0000_0077);
    check("sb10_data", r_wr_data, 32'h0BAD_770D);
    do_req(1'b0, 3'd2, 32'h02, 32'd0);
    check("cnt_err", 32'(r_err), 32'd1);
`ifdef MAU_PERF_CNT_EN
    check("cnt_loads", cnt_loads, 32'd3);
    check("cnt_stores", cnt_stores, 32'd2);
`else
    check("cnt_loads_off", cnt_loads, 32'd0);
    check("cnt_stores_off", cnt_stores, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
